// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// alignment checks.
package lsu_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} lsu_state_t;

    // Access size cannot be served at this byte offset.
    function automatic logic size_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic [2:0] funct3);
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // Drop the offset bits that the access size cannot use.
    function automatic logic [1:0] force_align(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_H, F3_HU: return {off[1], 1'b0};
            F3_W:        return 2'b00;
            default:     return off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables/replicated write data, and load
// byte/half selection with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_c,
    output logic [31:0] ext_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be_c    = '0;
        wdata_c = '0;
        case (funct3)
            F3_B, F3_BU: begin
                be_c    = 4'(4'b0001 << off);
                wdata_c = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                be_c    = 4'(4'b0011 << off);
                wdata_c = {2{wdata[15:0]}};
            end
            F3_W: begin
                be_c    = 4'b1111;
                wdata_c = wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext_c = '0;
        case (funct3)
            F3_B:    ext_c = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ext_c = {24'h0, byte_sel};
            F3_H:    ext_c = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ext_c = {16'h0, half_sel};
            F3_W:    ext_c = rdata;
            default: ext_c = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: valid/ready data-bus master that stalls the core until done.
// Define LSU_MISALIGN_EN to trap misaligned half/word accesses (err pulse) instead of aligning them.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          stall,
    output logic [DW-1:0] rdata,
    output logic          bus_valid,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_be,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ready,
    input  logic          bus_rvalid,
    input  logic [DW-1:0] bus_rdata,
    output logic          err
);

    lsu_state_t    state_q, state_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    off_q, off_d;
    logic          bus_valid_q, bus_valid_d;
    logic          bus_we_q, bus_we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [1:0]    req_off;
    logic [1:0]    off_eff;
    logic [2:0]    al_funct3;
    logic [1:0]    al_off;
    logic [3:0]    be_c;
    logic [31:0]   wdata_c;
    logic [31:0]   ext_c;

    assign req_off = req_addr[1:0];
`ifdef LSU_MISALIGN_EN
    logic err_q, err_d;
    assign off_eff = req_off;
`else
    assign off_eff = force_align(req_funct3, req_off);
`endif

    // The lane unit serves the incoming request in IDLE and the captured access afterwards.
    assign al_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;
    assign al_off    = (state_q == IDLE) ? off_eff    : off_q;

    lsu_align u_align (
        .funct3  (al_funct3),
        .off     (al_off),
        .wdata   (req_wdata),
        .rdata   (bus_rdata),
        .be_c    (be_c),
        .wdata_c (wdata_c),
        .ext_c   (ext_c)
    );

    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
`ifdef LSU_MISALIGN_EN
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d   = req_funct3;
                    off_d      = off_eff;
                    bus_we_d   = req_we;
                    bus_addr_d = {req_addr[AW-1:2], 2'b00};
                    rdata_d    = '0;
                    if (!funct3_legal(req_funct3)) begin
                        state_d = DONE;
`ifdef LSU_MISALIGN_EN
                    end else if (size_misaligned(req_funct3, req_off)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
`endif
                    end else begin
                        state_d     = REQ;
                        bus_valid_d = 1'b1;
                        bus_be_d    = req_we ? be_c : 4'b1111;
                        bus_wdata_d = req_we ? DW'(wdata_c) : '0;
                    end
                end
            end
            REQ: begin
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    if (bus_we_q) begin
                        state_d = DONE;
                    end else if (bus_rvalid) begin
                        rdata_d = DW'(ext_c);
                        state_d = DONE;
                    end else begin
                        state_d = RSP;
                    end
                end
            end
            RSP: begin
                if (bus_rvalid) begin
                    rdata_d = DW'(ext_c);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            funct3_q    <= '0;
            off_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef LSU_MISALIGN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Core is released on the DONE cycle and advances at the following edge.
    assign stall     = req_valid & (state_q != DONE);
    assign rdata     = rdata_q;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: stores, loads with extension, wait states,
// reset mid-access, misaligned and illegal accesses.
module tb_lsu_mem_stage;
    import lsu_pkg::*;

    logic        clk, reset;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;
    logic        err;

    int total = 0;
    int bad   = 0;

    lsu_mem_stage #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_we = 0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2 reset = 1'b0;
        #3;
        total++;
        if ({bus_valid, bus_we, bus_addr, bus_be, bus_wdata, rdata, err} !== 103'h0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", {bus_valid, bus_we, bus_addr, bus_be, bus_wdata, rdata, err});
        end
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall_idle got=%b exp=0", stall); end
        req_valid = 1; #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall_req got=%b exp=1", stall); end
        req_valid = 0;
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_sw();
        int n = 0;
        req_valid = 1; req_we = 1; req_funct3 = F3_W; req_addr = 32'h100; req_wdata = 32'hDEADBEEF;
        bus_ready = 1;
        #1 if (stall) n++;
        cyc();
        if (stall) n++;
        total++;
        if ({bus_valid, bus_we, bus_addr, bus_be, bus_wdata} !== {1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF}) begin
            bad++; $display("FAIL sw_req got=%b %b %h %h %h exp=1 1 100 f deadbeef", bus_valid, bus_we, bus_addr, bus_be, bus_wdata);
        end
        cyc();
        total++;
        if (stall !== 1'b0 || n != 2) begin bad++; $display("FAIL sw_stall got stall=%b cycles=%0d exp stall=0 cycles=2", stall, n); end
        total++;
        if (bus_valid !== 1'b0) begin bad++; $display("FAIL sw_done_valid got=%b exp=0", bus_valid); end
        idle_inputs();
        cyc();
    endtask

    task automatic test_sb_sh();
        req_valid = 1; req_we = 1; req_funct3 = F3_B; req_addr = 32'h103; req_wdata = 32'h000000A5;
        cyc();
        total++;
        if ({bus_addr, bus_be, bus_wdata} !== {32'h100, 4'b1000, 32'hA5A5A5A5}) begin
            bad++; $display("FAIL sb_lanes got=%h %b %h exp=100 1000 a5a5a5a5", bus_addr, bus_be, bus_wdata);
        end
        cyc();
        total++;
        if (bus_valid !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL sb_hold got valid=%b stall=%b exp 1 1", bus_valid, stall); end
        bus_ready = 1;
        cyc();
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL sb_done got=%b exp=0", stall); end
        idle_inputs();
        cyc();
        req_valid = 1; req_we = 1; req_funct3 = F3_H; req_addr = 32'h006; req_wdata = 32'h1234BEEF; bus_ready = 1;
        cyc();
        total++;
        if ({bus_addr, bus_be, bus_wdata} !== {32'h004, 4'b1100, 32'hBEEFBEEF}) begin
            bad++; $display("FAIL sh_lanes got=%h %b %h exp=4 1100 beefbeef", bus_addr, bus_be, bus_wdata);
        end
        cyc();
        idle_inputs();
        cyc();
    endtask

    task automatic test_lb_lbu();
        req_valid = 1; req_we = 0; req_funct3 = F3_B; req_addr = 32'h202;
        bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'h12F45678;
        cyc();
        total++;
        if ({bus_valid, bus_we, bus_addr, bus_be} !== {1'b1, 1'b0, 32'h200, 4'hF}) begin
            bad++; $display("FAIL lb_req got=%b %b %h %h exp=1 0 200 f", bus_valid, bus_we, bus_addr, bus_be);
        end
        cyc();
        total++;
        if (rdata !== 32'hFFFFFFF4 || stall !== 1'b0) begin bad++; $display("FAIL lb_data got=%h stall=%b exp=fffffff4 0", rdata, stall); end
        req_valid = 0;
        cyc();
        req_valid = 1; req_funct3 = F3_BU;
        cyc();
        cyc();
        total++;
        if (rdata !== 32'h000000F4) begin bad++; $display("FAIL lbu_data got=%h exp=000000f4", rdata); end
        idle_inputs();
        cyc();
    endtask

    task automatic test_lh_wait();
        int n = 0;
        req_valid = 1; req_we = 0; req_funct3 = F3_H; req_addr = 32'h002; bus_ready = 1;
        #1 if (stall) n++;
        cyc();
        if (stall) n++;
        cyc();
        if (stall) n++;
        bus_ready = 0;
        total++;
        if (bus_valid !== 1'b0) begin bad++; $display("FAIL lh_rsp_valid got=%b exp=0", bus_valid); end
        cyc();
        if (stall) n++;
        cyc();
        if (stall) n++;
        bus_rvalid = 1; bus_rdata = 32'h80017FFF;
        cyc();
        total++;
        if (rdata !== 32'hFFFF8001) begin bad++; $display("FAIL lh_data got=%h exp=ffff8001", rdata); end
        total++;
        if (stall !== 1'b0 || n != 5) begin bad++; $display("FAIL lh_stall got stall=%b cycles=%0d exp 0 5", stall, n); end
        idle_inputs();
        cyc();
    endtask

    task automatic test_reset_mid_rsp();
        req_valid = 1; req_we = 0; req_funct3 = F3_W; req_addr = 32'h300; bus_ready = 1;
        cyc();
        cyc();
        bus_ready = 0;
        reset = 1'b0;
        #1;
        total++;
        if (bus_valid !== 1'b0 || rdata !== 32'h0 || stall !== 1'b1) begin
            bad++; $display("FAIL rst_mid got valid=%b rdata=%h stall=%b exp 0 0 1", bus_valid, rdata, stall);
        end
        req_valid = 0;
        #1 reset = 1'b1;
        bus_rvalid = 1; bus_rdata = 32'hFFFFFFFF;
        cyc();
        cyc();
        total++;
        if (rdata !== 32'h0 || bus_valid !== 1'b0) begin bad++; $display("FAIL rst_stray got rdata=%h valid=%b exp 0 0", rdata, bus_valid); end
        idle_inputs();
        cyc();
    endtask

    task automatic test_misalign();
        req_valid = 1; req_we = 0; req_funct3 = F3_W; req_addr = 32'h101;
        bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'hCAFEF00D;
        cyc();
`ifdef LSU_MISALIGN_EN
        total++;
        if ({bus_valid, err, rdata, stall} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
            bad++; $display("FAIL mis_trap got valid=%b err=%b rdata=%h stall=%b exp 0 1 0 0", bus_valid, err, rdata, stall);
        end
        req_valid = 0;
        cyc();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL mis_err_pulse got=%b exp=0", err); end
`else
        total++;
        if ({bus_valid, bus_addr, err} !== {1'b1, 32'h100, 1'b0}) begin
            bad++; $display("FAIL mis_align_req got valid=%b addr=%h err=%b exp 1 100 0", bus_valid, bus_addr, err);
        end
        cyc();
        total++;
        if (rdata !== 32'hCAFEF00D || err !== 1'b0) begin bad++; $display("FAIL mis_align_data got=%h err=%b exp cafef00d 0", rdata, err); end
`endif
        idle_inputs();
        cyc();
    endtask

    task automatic test_illegal();
        req_valid = 1; req_we = 0; req_funct3 = F3_B; req_addr = 32'h010;
        bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'h00000077;
        cyc();
        cyc();
        req_valid = 0;
        cyc();
        req_valid = 1; req_funct3 = 3'b011;
        cyc();
        total++;
        if ({bus_valid, rdata, stall} !== {1'b0, 32'h0, 1'b0}) begin
            bad++; $display("FAIL illegal got valid=%b rdata=%h stall=%b exp 0 0 0", bus_valid, rdata, stall);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_back_to_back();
        req_valid = 1; req_we = 1; req_funct3 = F3_W; req_addr = 32'h010; req_wdata = 32'h11223344; bus_ready = 1;
        cyc();
        cyc();
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL b2b_st_done got=%b exp=0", stall); end
        req_we = 0; req_addr = 32'h044; bus_rvalid = 1; bus_rdata = 32'h55AA55AA;
        cyc();
        total++;
        if (stall !== 1'b1 || bus_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got stall=%b valid=%b exp 1 0", stall, bus_valid); end
        cyc();
        total++;
        if ({bus_we, bus_addr} !== {1'b0, 32'h044}) begin bad++; $display("FAIL b2b_ld_req got we=%b addr=%h exp 0 44", bus_we, bus_addr); end
        cyc();
        total++;
        if (rdata !== 32'h55AA55AA) begin bad++; $display("FAIL b2b_ld_data got=%h exp=55aa55aa", rdata); end
        idle_inputs();
        cyc();
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb_sh();
        test_lb_lbu();
        test_lh_wait();
        test_reset_mid_rsp();
        test_misalign();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
